ifetch_queue: RTL

- Parametrised instruction-fetch front end that replaces the single-request fetch stage.
- Issues sequential fetches on the sram-like instruction bus with up to MAX_OUTSTANDING requests in flight.
- Buffers returned instructions in a DEPTH-entry queue and hands them to the IF/ID register through a valid/ready port.
- Handles redirects (branch or exception) by flushing the queue and dropping stale in-flight responses; flags misaligned fetch addresses (AdEL) without issuing a bus request.

---
 rtl/ifetch_queue.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/ifetch_queue.sv
// Instruction-fetch front end: pipelined sram-like fetches feeding a DEPTH-entry queue,
// with redirect flush, stale-response dropping and AdEL reporting for misaligned PCs.
module ifetch_queue #(
    parameter int unsigned DEPTH           = 4,
    parameter int unsigned MAX_OUTSTANDING = 2,
    parameter logic [31:0] RESET_PC        = 32'hbfc00000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [31:0] out_inst,
    output logic        out_adel,
    output logic        inst_req,
    output logic        inst_wr,
    output logic [1:0]  inst_size,
    output logic [31:0] inst_addr,
    output logic [31:0] inst_wdata,
    input  logic [31:0] inst_rdata,
    input  logic        inst_addr_ok,
    input  logic        inst_data_ok
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = PW + 1;
    localparam int unsigned UW = CW + 1;

    logic [31:0]       r_fetch_pc;
    logic              r_halt;
    logic              r_req_held;
    logic              r_req_drop;
    logic [31:0]       r_req_addr;

    logic [31:0]       r_q_pc   [DEPTH];
    logic [31:0]       r_q_inst [DEPTH];
    logic [DEPTH-1:0]  r_q_adel;
    logic [PW-1:0]     r_q_rd;
    logic [PW-1:0]     r_q_wr;
    logic [CW-1:0]     r_q_cnt;

    logic [31:0]       r_p_addr [DEPTH];
    logic [DEPTH-1:0]  r_p_drop;
    logic [PW-1:0]     r_p_rd;
    logic [PW-1:0]     r_p_wr;
    logic [CW-1:0]     r_p_cnt;

    logic              r_out_valid;
    logic [31:0]       r_out_pc;
    logic [31:0]       r_out_inst;
    logic              r_out_adel;

    logic [UW-1:0]     w_used;
    logic              w_credit_ok;
    logic              w_room;
    logic              w_aligned;
    logic              w_accept;
    logic              w_resp;
    logic              w_resp_keep;
    logic              w_new_req;
    logic              w_adel_push;
    logic              w_q_push;
    logic              w_q_pop;
    logic [31:0]       w_push_pc;
    logic [31:0]       w_push_inst;
    logic [CW-1:0]     w_q_left;
    logic [PW-1:0]     w_q_rd_nxt;

    // Credit counts queue slots plus every accepted-but-unanswered request.
    assign w_used      = UW'(r_q_cnt) + UW'(r_p_cnt);
    assign w_credit_ok = w_used < UW'(DEPTH);
    assign w_room      = r_p_cnt < CW'(MAX_OUTSTANDING);
    assign w_aligned   = (r_fetch_pc[1:0] == 2'b00);

    assign w_accept    = r_req_held & inst_addr_ok;
    assign w_resp      = inst_data_ok & (r_p_cnt != '0);
    assign w_resp_keep = w_resp & ~r_p_drop[r_p_rd] & ~redirect;
    assign w_new_req   = ~r_req_held & ~redirect & ~r_halt & w_aligned & w_credit_ok & w_room;
    assign w_adel_push = ~r_req_held & ~redirect & ~r_halt & ~w_aligned & w_credit_ok
                       & (r_p_cnt == '0);

    assign w_q_push    = w_resp_keep | w_adel_push;
    assign w_q_pop     = (r_q_cnt != '0) & out_ready & ~redirect;
    assign w_push_pc   = w_adel_push ? r_fetch_pc : r_p_addr[r_p_rd];
    assign w_push_inst = w_adel_push ? 32'd0 : inst_rdata;
    assign w_q_left    = r_q_cnt - CW'(w_q_pop);
    assign w_q_rd_nxt  = r_q_rd + PW'(w_q_pop);

    // Fetch PC, halt and the held bus request; a held request survives redirects as stale.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_fetch_pc <= RESET_PC;
            r_halt     <= 1'b0;
            r_req_held <= 1'b0;
            r_req_drop <= 1'b0;
            r_req_addr <= 32'd0;
        end else begin
            if (redirect) begin
                r_fetch_pc <= redirect_pc;
                r_halt     <= 1'b0;
            end else begin
                if (w_accept & ~r_req_drop) r_fetch_pc <= r_fetch_pc + 32'd4;
                if (w_adel_push)            r_halt     <= 1'b1;
            end
            if (w_new_req) begin
                r_req_held <= 1'b1;
                r_req_addr <= r_fetch_pc;
                r_req_drop <= 1'b0;
            end else if (w_accept) begin
                r_req_held <= 1'b0;
            end
            if (redirect & r_req_held & ~w_accept) r_req_drop <= 1'b1;
        end
    end

    // Pending FIFO control; a redirect poisons every entry, including one accepted now.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_p_rd   <= '0;
            r_p_wr   <= '0;
            r_p_cnt  <= '0;
            r_p_drop <= '0;
        end else begin
            if (redirect) r_p_drop <= '1;
            if (w_accept) begin
                r_p_drop[r_p_wr] <= r_req_drop | redirect;
                r_p_wr           <= r_p_wr + PW'(1);
            end
            if (w_resp) r_p_rd <= r_p_rd + PW'(1);
            r_p_cnt <= r_p_cnt + CW'(w_accept) - CW'(w_resp);
        end
    end

    always_ff @(posedge clk) begin
        if (rst || redirect) begin
            r_q_rd  <= '0;
            r_q_wr  <= '0;
            r_q_cnt <= '0;
        end else begin
            if (w_q_push) r_q_wr <= r_q_wr + PW'(1);
            r_q_rd  <= w_q_rd_nxt;
            r_q_cnt <= w_q_left + CW'(w_q_push);
        end
    end

    always_ff @(posedge clk) begin
        if (w_q_push) begin
            r_q_pc[r_q_wr]   <= w_push_pc;
            r_q_inst[r_q_wr] <= w_push_inst;
            r_q_adel[r_q_wr] <= w_adel_push;
        end
        if (w_accept) r_p_addr[r_p_wr] <= r_req_addr;
    end

    // Head register holds the entry that will sit at the queue head after this edge.
    always_ff @(posedge clk) begin
        if (rst || redirect) begin
            r_out_valid <= 1'b0;
            r_out_pc    <= 32'd0;
            r_out_inst  <= 32'd0;
            r_out_adel  <= 1'b0;
        end else if (w_q_left != '0) begin
            r_out_valid <= 1'b1;
            r_out_pc    <= r_q_pc[w_q_rd_nxt];
            r_out_inst  <= r_q_inst[w_q_rd_nxt];
            r_out_adel  <= r_q_adel[w_q_rd_nxt];
        end else if (w_q_push) begin
            r_out_valid <= 1'b1;
            r_out_pc    <= w_push_pc;
            r_out_inst  <= w_push_inst;
            r_out_adel  <= w_adel_push;
        end else begin
            r_out_valid <= 1'b0;
            r_out_pc    <= 32'd0;
            r_out_inst  <= 32'd0;
            r_out_adel  <= 1'b0;
        end
    end

    assign out_valid  = r_out_valid;
    assign out_pc     = r_out_pc;
    assign out_inst   = r_out_inst;
    assign out_adel   = r_out_adel;
    assign inst_req   = r_req_held;
    assign inst_addr  = r_req_addr;
    assign inst_wr    = 1'b0;
    assign inst_size  = 2'b10;
    assign inst_wdata = 32'd0;

endmodule
